rps_round_ctrl: RTL and testbench
=================================

RPS_ROUND_CTRL -- requirements
Module: rps_round_ctrl

Interface
REQ-001 Parameter WIN_TARGET, default 2, round wins needed to take the match (legal 1..15; best-of-3 at default).
REQ-002 Parameter TIMEOUT, default 200, COLLECT cycles allowed before a round is forfeited (legal 1..255).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a new match.
REQ-006 lockA / lockB  in  1 each  player commits current move.
REQ-007 inA / inB  in  3 each  raw one-hot move: bit0 Rock, bit1 Paper, bit2 Scissors.
REQ-008 capA / capB  out  3 each  captured moves; drive the move validator's inA/inB.
REQ-009 valid  in  1  validator verdict on capA/capB (combinational return).
REQ-010 result  out  2  round outcome: 00 none, 01 A wins, 10 B wins, 11 draw.
REQ-011 result_vld  out  1  one-cycle pulse qualifying result.
REQ-012 err  out  1  one-cycle pulse when a captured move pair is invalid.
REQ-013 scoreA / scoreB  out  4 each  round wins in the current match.
REQ-014 match_done  out  1  level; high while in DONE.
REQ-015 match_winner  out  2  01 A, 10 B, 00 otherwise; held through DONE.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, EVAL, DONE; encoding free.
REQ-017 IDLE: start -> COLLECT; scores, capA/capB, gotA/gotB flags and timer cleared.
REQ-018 COLLECT: lockA with gotA=0 captures inA into capA and sets gotA; lockA with gotA=1 ignored (first lock wins); same for B.
REQ-019 Simultaneous lockA and lockB in one cycle SHALL capture both.
REQ-020 COLLECT -> EVAL on the edge where gotA and gotB are both set (including a capture on that same edge).
REQ-021 Timer SHALL clear on COLLECT entry and increment each COLLECT cycle; in the cycle where timer==TIMEOUT-1 and at least one got flag is still clear, the round SHALL forfeit.
REQ-022 Forfeit, only A locked: result=01, scoreA+1. Only B locked: result=10, scoreB+1. Neither locked: result=11. No validity check is made on a forfeit.
REQ-023 EVAL, valid=0: err pulses next cycle; scores unchanged; no result_vld; flags cleared; return to COLLECT (round replayed).
REQ-024 EVAL, valid=1: Paper beats Rock, Scissors beats Paper, Rock beats Scissors; equal moves give draw (11, no score change); the winner's score increments by 1.
REQ-025 Latency: both captures on edge N -> EVAL during cycle N+1 -> result/result_vld/score update visible in cycle N+2.
REQ-026 result SHALL hold its last value between pulses; result_vld and err SHALL never be high together.
REQ-027 After a scoring round or forfeit: if the updated score equals WIN_TARGET -> DONE with match_winner set, match_done high from the same cycle as result_vld; otherwise -> COLLECT with flags/timer cleared.
REQ-028 Scores SHALL never exceed WIN_TARGET; no wrap.
REQ-029 start SHALL be ignored in COLLECT and EVAL.
REQ-030 DONE: outputs held; start clears scores/result/match_winner and enters COLLECT.

Reset
REQ-031 rst in any state SHALL force IDLE on the next edge, with capA=capB=000, result=00, result_vld=0, err=0, scoreA=scoreB=0, match_done=0, match_winner=00, timer and flags cleared.
REQ-032 rst SHALL take priority over start, locks and timeout in the same cycle.

Verification
REQ-033 start; inA=001 lockA, inB=010 lockB in the same cycle -> two cycles later result=10, result_vld=1, scoreB=1.
REQ-034 inA=011 and inB=100 locked (valid=0) -> err pulse, scores unchanged, re-lock inA=100, inB=010 -> result=01, scoreA=1.
REQ-035 TIMEOUT=5, only lockA, held for 5 cycles -> result=01, scoreA+1; no locks at all -> result=11, scores unchanged.
REQ-036 A wins 2 rounds (WIN_TARGET=2) -> match_done=1, match_winner=01, further locks ignored; start -> scores 0, COLLECT.
REQ-037 lockA pulsed twice with different inA -> capA holds the first value; inA=inB=001 -> result=11.
REQ-038 rst asserted during EVAL with a pending win -> no result_vld, all outputs at reset values next cycle.

Source files
------------

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: captures both players' moves, scores
// each round via an external validator, handles forfeits, and tracks the match.
module rps_round_ctrl #(
  parameter int WIN_TARGET = 2,
  parameter int TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lockA,
  input  logic       lockB,
  input  logic [2:0] inA,
  input  logic [2:0] inB,
  output logic [2:0] capA,
  output logic [2:0] capB,
  input  logic       valid,
  output logic [1:0] result,
  output logic       result_vld,
  output logic       err,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic       match_done,
  output logic [1:0] match_winner
);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} state_e;

  localparam logic [3:0] WIN_SCORE  = 4'(WIN_TARGET);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic       got_a_q, got_a_d, got_b_q, got_b_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] result_q, result_d;
  logic       result_vld_q, result_vld_d;
  logic       err_q, err_d;
  logic [3:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic [1:0] winner_q, winner_d;
  logic       point_a, point_b;
  logic       got_a_n, got_b_n;

  // True when move x beats move y (both one-hot: bit0 R, bit1 P, bit2 S).
  function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
    return (x[1] & y[0]) | (x[2] & y[1]) | (x[0] & y[2]);
  endfunction

  always_comb begin
    state_d      = state_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    got_a_d      = got_a_q;
    got_b_d      = got_b_q;
    timer_d      = timer_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    err_d        = 1'b0;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    winner_d     = winner_q;
    point_a      = 1'b0;
    point_b      = 1'b0;
    got_a_n      = got_a_q | lockA;
    got_b_n      = got_b_q | lockB;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          cap_a_d   = 3'b000;
          cap_b_d   = 3'b000;
          got_a_d   = 1'b0;
          got_b_d   = 1'b0;
          timer_d   = 8'd0;
          score_a_d = 4'd0;
          score_b_d = 4'd0;
        end
      end
      COLLECT: begin
        if (lockA && !got_a_q) begin
          cap_a_d = inA;
          got_a_d = 1'b1;
        end
        if (lockB && !got_b_q) begin
          cap_b_d = inB;
          got_b_d = 1'b1;
        end
        timer_d = timer_q + 8'd1;
        if (got_a_n && got_b_n) begin
          state_d = EVAL;
          timer_d = 8'd0;
        end else if (timer_q == TIMER_LAST) begin
          // Forfeit: whoever has committed takes the round, no validity check.
          result_vld_d = 1'b1;
          got_a_d      = 1'b0;
          got_b_d      = 1'b0;
          timer_d      = 8'd0;
          if (got_a_n) begin
            result_d = 2'b01;
            point_a  = 1'b1;
          end else if (got_b_n) begin
            result_d = 2'b10;
            point_b  = 1'b1;
          end else begin
            result_d = 2'b11;
          end
        end
      end
      EVAL: begin
        state_d = COLLECT;
        got_a_d = 1'b0;
        got_b_d = 1'b0;
        timer_d = 8'd0;
        if (!valid) begin
          err_d = 1'b1;
        end else begin
          result_vld_d = 1'b1;
          if (cap_a_q == cap_b_q) begin
            result_d = 2'b11;
          end else if (beats(cap_a_q, cap_b_q)) begin
            result_d = 2'b01;
            point_a  = 1'b1;
          end else begin
            result_d = 2'b10;
            point_b  = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = COLLECT;
          cap_a_d   = 3'b000;
          cap_b_d   = 3'b000;
          got_a_d   = 1'b0;
          got_b_d   = 1'b0;
          timer_d   = 8'd0;
          score_a_d = 4'd0;
          score_b_d = 4'd0;
          result_d  = 2'b00;
          winner_d  = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    // Scores saturate at the target; reaching it ends the match.
    if (point_a && (score_a_q < WIN_SCORE)) begin
      score_a_d = score_a_q + 4'd1;
      if (score_a_d == WIN_SCORE) begin
        state_d  = DONE;
        winner_d = 2'b01;
      end
    end
    if (point_b && (score_b_q < WIN_SCORE)) begin
      score_b_d = score_b_q + 4'd1;
      if (score_b_d == WIN_SCORE) begin
        state_d  = DONE;
        winner_d = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cap_a_q      <= 3'b000;
      cap_b_q      <= 3'b000;
      got_a_q      <= 1'b0;
      got_b_q      <= 1'b0;
      timer_q      <= 8'd0;
      result_q     <= 2'b00;
      result_vld_q <= 1'b0;
      err_q        <= 1'b0;
      score_a_q    <= 4'd0;
      score_b_q    <= 4'd0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      got_a_q      <= got_a_d;
      got_b_q      <= got_b_d;
      timer_q      <= timer_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      err_q        <= err_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      winner_q     <= winner_d;
    end
  end

  assign capA         = cap_a_q;
  assign capB         = cap_b_q;
  assign result       = result_q;
  assign result_vld   = result_vld_q;
  assign err          = err_q;
  assign scoreA       = score_a_q;
  assign scoreB       = score_b_q;
  assign match_done   = (state_q == DONE);
  assign match_winner = winner_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed self-checking bench for rps_round_ctrl (WIN_TARGET=2, TIMEOUT=5),
// with a behavioural one-hot move validator closing the valid loop.
module tb_rps_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       lockA = 1'b0;
  logic       lockB = 1'b0;
  logic [2:0] inA = 3'b000;
  logic [2:0] inB = 3'b000;
  logic [2:0] capA, capB;
  logic       valid;
  logic [1:0] result;
  logic       result_vld, err;
  logic [3:0] scoreA, scoreB;
  logic       match_done;
  logic [1:0] match_winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External validator: both captured moves must be exactly one-hot.
  assign valid = ($countones(capA) == 1) && ($countones(capB) == 1);

  rps_round_ctrl #(.WIN_TARGET(2), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .lockA(lockA), .lockB(lockB),
    .inA(inA), .inB(inB), .capA(capA), .capB(capB), .valid(valid),
    .result(result), .result_vld(result_vld), .err(err),
    .scoreA(scoreA), .scoreB(scoreB), .match_done(match_done),
    .match_winner(match_winner)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_locks(input logic la, input logic [2:0] a, input logic lb, input logic [2:0] b);
    lockA = la; inA = a;
    lockB = lb; inB = b;
  endtask

  initial begin
    // Reset
    tick(); tick();
    check_eq("rst_result", 32'(result), 32'h0);
    check_eq("rst_vld", 32'(result_vld), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_scores", {24'h0, scoreA, scoreB}, 32'h0);
    check_eq("rst_done", 32'(match_done), 32'h0);
    check_eq("rst_winner", 32'(match_winner), 32'h0);
    check_eq("rst_caps", {26'h0, capA, capB}, 32'h0);
    rst = 1'b0;

    // Rock vs Paper, simultaneous locks: B wins two cycles later
    start = 1'b1; tick(); start = 1'b0;
    set_locks(1'b1, 3'b001, 1'b1, 3'b010); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    check_eq("r1_eval_no_vld", 32'(result_vld), 32'h0);
    tick();
    check_eq("r1_result", 32'(result), 32'h2);
    check_eq("r1_vld", 32'(result_vld), 32'h1);
    check_eq("r1_scores", {24'h0, scoreA, scoreB}, 32'h01);
    check_eq("r1_caps", {26'h0, capA, capB}, {26'h0, 3'b001, 3'b010});
    tick();
    check_eq("r1_vld_pulse", 32'(result_vld), 32'h0);
    check_eq("r1_result_hold", 32'(result), 32'h2);

    // Invalid pair: err pulse, round replayed, then Scissors beats Paper
    set_locks(1'b1, 3'b011, 1'b1, 3'b100); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000); tick();
    check_eq("inv_err", 32'(err), 32'h1);
    check_eq("inv_no_vld", 32'(result_vld), 32'h0);
    check_eq("inv_scores", {24'h0, scoreA, scoreB}, 32'h01);
    set_locks(1'b1, 3'b100, 1'b1, 3'b010); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    check_eq("inv_err_pulse", 32'(err), 32'h0);
    tick();
    check_eq("r2_result", 32'(result), 32'h1);
    check_eq("r2_vld", 32'(result_vld), 32'h1);
    check_eq("r2_scores", {24'h0, scoreA, scoreB}, 32'h11);

    // First lock wins; Rock vs Rock is a draw
    set_locks(1'b1, 3'b001, 1'b0, 3'b000); tick();
    set_locks(1'b1, 3'b010, 1'b0, 3'b000); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    check_eq("first_lock_capA", 32'(capA), 32'h1);
    set_locks(1'b0, 3'b000, 1'b1, 3'b001); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000); tick();
    check_eq("draw_result", 32'(result), 32'h3);
    check_eq("draw_vld", 32'(result_vld), 32'h1);
    check_eq("draw_scores", {24'h0, scoreA, scoreB}, 32'h11);

    // Timeout with no locks: draw, no score change, exactly after 5 cycles
    tick(); tick(); tick(); tick();
    check_eq("to_none_early", 32'(result_vld), 32'h0);
    tick();
    check_eq("to_none_result", 32'(result), 32'h3);
    check_eq("to_none_vld", 32'(result_vld), 32'h1);
    check_eq("to_none_scores", {24'h0, scoreA, scoreB}, 32'h11);

    // Timeout with only A locked: A takes the round and the match
    set_locks(1'b1, 3'b010, 1'b0, 3'b000); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    tick(); tick(); tick();
    check_eq("to_a_early", 32'(result_vld), 32'h0);
    tick();
    check_eq("to_a_result", 32'(result), 32'h1);
    check_eq("to_a_vld", 32'(result_vld), 32'h1);
    check_eq("to_a_scores", {24'h0, scoreA, scoreB}, 32'h21);
    check_eq("match_done_a", 32'(match_done), 32'h1);
    check_eq("winner_a", 32'(match_winner), 32'h1);

    // DONE ignores locks and holds outputs
    set_locks(1'b1, 3'b001, 1'b1, 3'b100); tick(); tick(); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    check_eq("done_hold_scores", {24'h0, scoreA, scoreB}, 32'h21);
    check_eq("done_hold_level", 32'(match_done), 32'h1);
    check_eq("done_hold_winner", 32'(match_winner), 32'h1);
    check_eq("done_hold_capA", 32'(capA), 32'h2);
    check_eq("done_no_vld", 32'(result_vld), 32'h0);

    // start from DONE clears the match
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_scores", {24'h0, scoreA, scoreB}, 32'h0);
    check_eq("restart_result", 32'(result), 32'h0);
    check_eq("restart_done", 32'(match_done), 32'h0);
    check_eq("restart_winner", 32'(match_winner), 32'h0);

    // Timeout with only B locked
    set_locks(1'b0, 3'b000, 1'b1, 3'b001); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    tick(); tick(); tick(); tick();
    check_eq("to_b_result", 32'(result), 32'h2);
    check_eq("to_b_vld", 32'(result_vld), 32'h1);
    check_eq("to_b_scores", {24'h0, scoreA, scoreB}, 32'h01);

    // Reset during EVAL with an A win pending
    set_locks(1'b1, 3'b010, 1'b1, 3'b001); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0;
    check_eq("evrst_vld", 32'(result_vld), 32'h0);
    check_eq("evrst_result", 32'(result), 32'h0);
    check_eq("evrst_scores", {24'h0, scoreA, scoreB}, 32'h0);
    check_eq("evrst_caps", {26'h0, capA, capB}, 32'h0);
    check_eq("evrst_done", 32'(match_done), 32'h0);

    // B wins the match in two rounds; start during EVAL is ignored
    start = 1'b1; tick(); start = 1'b0;
    set_locks(1'b1, 3'b001, 1'b1, 3'b010); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000); tick();
    check_eq("b1_scores", {24'h0, scoreA, scoreB}, 32'h01);
    set_locks(1'b1, 3'b100, 1'b1, 3'b001); tick();
    set_locks(1'b0, 3'b000, 1'b0, 3'b000);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("b2_result", 32'(result), 32'h2);
    check_eq("b2_scores", {24'h0, scoreA, scoreB}, 32'h02);
    check_eq("b2_done", 32'(match_done), 32'h1);
    check_eq("b2_winner", 32'(match_winner), 32'h2);
    check_eq("b2_vld_no_err", {30'h0, result_vld, err}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
